// File: rtl/srio_selfcheck_ctrl.sv
// Self-check handshake sequencer: takes a CPU command byte, pulses RapidIO self-check,
// waits for DSP ready with timeout/retry, and returns one status byte to the CPU.
module srio_selfcheck_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRY      = 3,
    parameter int RETRY_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         cmd_axis_tdata_in,
    input  logic               cmd_axis_tvalid_in,
    input  logic               cmd_axis_tlast_in,
    output logic               cmd_axis_tready_out,
    output logic               self_check_out,
    input  logic               dsp_ready_in,
    output logic [7:0]         cmd2cpu_tdata_out,
    output logic               cmd2cpu_tvalid_out,
    output logic               cmd2cpu_tlast_out,
    input  logic               cmd2cpu_tready_in,
    output logic               busy_out,
    output logic [RETRY_W-1:0] retry_cnt_out
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0]         CMD_SELF_CHECK_REQ = 8'h21;
    localparam logic [7:0]         STS_DSP_READY      = 8'h25;
    localparam logic [7:0]         STS_DSP_NOT_READY  = 8'h2a;
    localparam logic [TMR_W-1:0]   TMR_LAST           = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT        = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [RETRY_W-1:0] r_retry;
    logic               r_self_check;
    logic               r_tvalid;
    logic [7:0]         r_tdata;
    logic               r_busy;

    logic               w_cmd_hs;
    logic               w_unused_tlast;

    // Commands are single-byte, so tlast carries no information.
    assign w_unused_tlast      = cmd_axis_tlast_in;

    assign cmd_axis_tready_out = (r_state == S_IDLE);
    assign w_cmd_hs            = cmd_axis_tvalid_in && cmd_axis_tready_out;

    assign self_check_out      = r_self_check;
    assign cmd2cpu_tdata_out   = r_tdata;
    assign cmd2cpu_tvalid_out  = r_tvalid;
    assign cmd2cpu_tlast_out   = r_tvalid;
    assign busy_out            = r_busy;
    assign retry_cnt_out       = r_retry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_retry      <= '0;
            r_self_check <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Non-self-check bytes are consumed by the handshake and dropped.
                    if (w_cmd_hs && cmd_axis_tdata_in == CMD_SELF_CHECK_REQ) begin
                        r_state      <= S_REQ;
                        r_self_check <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_self_check <= 1'b0;
                    r_timer      <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (dsp_ready_in) begin
                        r_state  <= S_RESP;
                        r_tvalid <= 1'b1;
                        r_tdata  <= STS_DSP_READY;
                    end else if (r_timer == TMR_LAST) begin
                        if (r_retry < RETRY_LIMIT) begin
                            r_retry      <= r_retry + RETRY_W'(1);
                            r_state      <= S_REQ;
                            r_self_check <= 1'b1;
                        end else begin
                            r_state  <= S_RESP;
                            r_tvalid <= 1'b1;
                            r_tdata  <= STS_DSP_NOT_READY;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    if (cmd2cpu_tready_in) begin
                        r_state  <= S_IDLE;
                        r_tvalid <= 1'b0;
                        r_tdata  <= '0;
                        r_retry  <= '0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_self_check <= 1'b0;
                    r_tvalid     <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srio_selfcheck_ctrl.sv
// Bench for srio_selfcheck_ctrl: table of command scenarios plus hand-written
// back-pressure and mid-sequence reset cases; status bytes checked via a queue.
module tb_srio_selfcheck_ctrl;

    localparam int TOUT = 16;
    localparam int MAXR = 2;
    localparam int RW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    cmd_axis_tdata_in;
    logic          cmd_axis_tvalid_in;
    logic          cmd_axis_tlast_in;
    logic          cmd_axis_tready_out;
    logic          self_check_out;
    logic          dsp_ready_in;
    logic [7:0]    cmd2cpu_tdata_out;
    logic          cmd2cpu_tvalid_out;
    logic          cmd2cpu_tlast_out;
    logic          cmd2cpu_tready_in;
    logic          busy_out;
    logic [RW-1:0] retry_cnt_out;

    srio_selfcheck_ctrl #(
        .TIMEOUT_CYCLES(TOUT),
        .MAX_RETRY     (MAXR),
        .RETRY_W       (RW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_axis_tdata_in  (cmd_axis_tdata_in),
        .cmd_axis_tvalid_in (cmd_axis_tvalid_in),
        .cmd_axis_tlast_in  (cmd_axis_tlast_in),
        .cmd_axis_tready_out(cmd_axis_tready_out),
        .self_check_out     (self_check_out),
        .dsp_ready_in       (dsp_ready_in),
        .cmd2cpu_tdata_out  (cmd2cpu_tdata_out),
        .cmd2cpu_tvalid_out (cmd2cpu_tvalid_out),
        .cmd2cpu_tlast_out  (cmd2cpu_tlast_out),
        .cmd2cpu_tready_in  (cmd2cpu_tready_in),
        .busy_out           (busy_out),
        .retry_cnt_out      (retry_cnt_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] status;
        logic [3:0] retry;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] cmd;
        int         rdy_att;   // attempt in which ready is raised, 0 = never
        int         rdy_n;     // WAIT cycle (1-based) of that attempt
        logic [7:0] status;
        int         retry;
        int         pulses;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Status stream scoreboard: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (cmd2cpu_tvalid_out && cmd2cpu_tready_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_status", {24'd0, cmd2cpu_tdata_out}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("status_tdata", {24'd0, cmd2cpu_tdata_out}, {24'd0, e.status});
                check("status_tlast", {31'd0, cmd2cpu_tlast_out}, 32'd1);
                check("status_retry", {28'd0, retry_cnt_out}, {28'd0, e.retry});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b, output int hs);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        hs  = -1;
        cmd_axis_tdata_in  = b;
        cmd_axis_tvalid_in = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cmd_axis_tready_out;
            if (acc) hs = cyc;
            step();
            n++;
        end
        cmd_axis_tvalid_in = 1'b0;
        cmd_axis_tdata_in  = 8'h00;
        if (!acc) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic await_resp(input int hs, input int rdy_att, input int rdy_n,
                              input int exp_pulses, input bit hold);
        int  pulses;
        int  last_p;
        int  rdy_cyc;
        int  n;
        bit  done;
        pulses  = 0;
        last_p  = -1000;
        rdy_cyc = -1;
        n       = 0;
        done    = 1'b0;
        while (!done && n < 300) begin
            dsp_ready_in = (rdy_att != 0 && pulses == rdy_att && cyc == last_p + rdy_n);
            if (dsp_ready_in) rdy_cyc = cyc;
            @(negedge clk);
            if (self_check_out) begin
                pulses++;
                if (pulses == 1) begin
                    check("first_pulse_cycle", cyc, hs + 1);
                    check("busy_in_req", {31'd0, busy_out}, 32'd1);
                end else begin
                    check("pulse_spacing", cyc - last_p, TOUT + 1);
                end
                last_p = cyc;
            end
            if (cmd2cpu_tvalid_out) begin
                done = 1'b1;
                if (rdy_cyc >= 0) check("ready_latency", cyc, rdy_cyc + 1);
                else              check("timeout_latency", cyc, last_p + TOUT + 1);
            end
            step();
            n++;
        end
        dsp_ready_in = 1'b0;
        if (!done) check("resp_wait_expired", 32'd0, 32'd1);
        check("pulse_count", pulses, exp_pulses);
        if (!hold) begin
            @(negedge clk);
            check("idle_tready", {31'd0, cmd_axis_tready_out}, 32'd1);
            check("idle_busy", {31'd0, busy_out}, 32'd0);
            check("idle_tvalid", {31'd0, cmd2cpu_tvalid_out}, 32'd0);
            check("idle_tdata", {24'd0, cmd2cpu_tdata_out}, 32'd0);
            check("idle_retry", {28'd0, retry_cnt_out}, 32'd0);
            step();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   hs;
        exp_t e;
        if (v.cmd == 8'h21) begin
            e.status = v.status;
            e.retry  = 4'(v.retry);
            exp_q.push_back(e);
            send_cmd(v.cmd, hs);
            await_resp(hs, v.rdy_att, v.rdy_n, v.pulses, 1'b0);
        end else begin
            send_cmd(v.cmd, hs);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("ignored_busy", {31'd0, busy_out}, 32'd0);
                check("ignored_pulse", {31'd0, self_check_out}, 32'd0);
                check("ignored_tvalid", {31'd0, cmd2cpu_tvalid_out}, 32'd0);
                step();
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"}, {31'd0, cmd_axis_tready_out}, 32'd1);
        check({tag, "_pulse"}, {31'd0, self_check_out}, 32'd0);
        check({tag, "_tvalid"}, {31'd0, cmd2cpu_tvalid_out}, 32'd0);
        check({tag, "_tlast"}, {31'd0, cmd2cpu_tlast_out}, 32'd0);
        check({tag, "_tdata"}, {24'd0, cmd2cpu_tdata_out}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
        check({tag, "_retry"}, {28'd0, retry_cnt_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int   hs;
        int   hs_exp;
        int   pulses;
        int   n;
        bit   acc;
        exp_t e;

        vecs[0] = '{cmd: 8'h21, rdy_att: 1, rdy_n: 5,  status: 8'h25, retry: 0, pulses: 1};
        vecs[1] = '{cmd: 8'h21, rdy_att: 0, rdy_n: 0,  status: 8'h2a, retry: 2, pulses: 3};
        vecs[2] = '{cmd: 8'h21, rdy_att: 2, rdy_n: 16, status: 8'h25, retry: 1, pulses: 2};
        vecs[3] = '{cmd: 8'h33, rdy_att: 0, rdy_n: 0,  status: 8'h00, retry: 0, pulses: 0};
        vecs[4] = '{cmd: 8'h21, rdy_att: 3, rdy_n: 1,  status: 8'h25, retry: 2, pulses: 3};
        vecs[5] = '{cmd: 8'h21, rdy_att: 1, rdy_n: 16, status: 8'h25, retry: 0, pulses: 1};

        reset              = 1'b1;
        cmd_axis_tdata_in  = 8'h00;
        cmd_axis_tvalid_in = 1'b0;
        cmd_axis_tlast_in  = 1'b1;
        dsp_ready_in       = 1'b0;
        cmd2cpu_tready_in  = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-pressure: status held while CPU stalls; a queued command waits for IDLE.
        cmd2cpu_tready_in = 1'b0;
        e.status = 8'h25; e.retry = 4'd0;
        exp_q.push_back(e);
        send_cmd(8'h21, hs);
        await_resp(hs, 1, 3, 1, 1'b1);
        cmd_axis_tdata_in  = 8'h21;
        cmd_axis_tvalid_in = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_tvalid", {31'd0, cmd2cpu_tvalid_out}, 32'd1);
            check("bp_tdata", {24'd0, cmd2cpu_tdata_out}, 32'h25);
            check("bp_cmd_tready", {31'd0, cmd_axis_tready_out}, 32'd0);
            step();
        end
        cmd2cpu_tready_in = 1'b1;
        hs_exp = cyc + 1;
        acc = 1'b0;
        n   = 0;
        hs  = -1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = cmd_axis_tready_out;
            if (acc) hs = cyc;
            step();
            n++;
        end
        cmd_axis_tvalid_in = 1'b0;
        cmd_axis_tdata_in  = 8'h00;
        check("b2b_accept_cycle", hs, hs_exp);
        await_resp(hs, 1, 2, 1, 1'b0);

        // Reset during the second attempt's WAIT aborts without a status byte.
        e.status = 8'h2a; e.retry = 4'd2;
        exp_q.push_back(e);
        send_cmd(8'h21, hs);
        pulses = 0;
        n      = 0;
        while (pulses < 2 && n < 100) begin
            @(negedge clk);
            if (self_check_out) pulses++;
            step();
            n++;
        end
        check("rst_second_attempt", pulses, 2);
        repeat (3) step();
        @(negedge clk);
        check("rst_pre_retry", {28'd0, retry_cnt_out}, 32'd1);
        check("rst_pre_busy", {31'd0, busy_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_tvalid", {31'd0, cmd2cpu_tvalid_out}, 32'd0);
            step();
        end
        run_vec(vecs[0]);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/srio_selfcheck_ctrl.md
Name: srio_selfcheck_ctrl

Overview:
Sequences the RapidIO/DSP self-check handshake on behalf of the CPU command channel.
- Accepts an 8-bit AXI-Stream command byte from the CPU.
- Issues a one-cycle self-check pulse towards RapidIO, then waits for dsp_ready with a bounded timeout.
- Retries up to MAX_RETRY times, then returns exactly one status byte to the CPU over a back-pressured AXI-Stream.
- Sits between the CPU command path and the RapidIO self-check logic; owns the only cpu-feedback stream for self-check.

Parameters:
TIMEOUT_CYCLES, 1000, number of WAIT cycles without dsp_ready before an attempt fails (>=2).
MAX_RETRY, 3, number of additional attempts after the first failed attempt (0..15).
RETRY_W, 4, width of the retry counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_axis_tdata_in  in  8  CPU command byte
cmd_axis_tvalid_in  in  1  command valid
cmd_axis_tlast_in  in  1  command last (ignored; single-byte commands)
cmd_axis_tready_out  out  1  command ready; 1 only in IDLE
self_check_out  out  1  one-cycle self-check request to RapidIO
dsp_ready_in  in  1  DSP ready indication (level or pulse)
cmd2cpu_tdata_out  out  8  status byte to CPU
cmd2cpu_tvalid_out  out  1  status valid
cmd2cpu_tlast_out  out  1  status last; equals tvalid
cmd2cpu_tready_in  in  1  CPU ready
busy_out  out  1  1 in any state other than IDLE
retry_cnt_out  out  RETRY_W  attempts already failed in the current sequence

Behaviour:
- Reset: state=IDLE.
- Reset values: all outputs 0 except cmd_axis_tready_out=1. Timer=0, retry=0.
- Reset mid-sequence aborts immediately; no status byte is emitted.
- Command codes: SELF_CHECK_REQ=8'h21. Status codes: DSP_READY=8'h25, DSP_NOT_READY=8'h2a.
- All outputs are registered except cmd_axis_tready_out, which is decoded from state.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Command handshake = tvalid && tready.
  - Byte 8'h21 accepted -> REQ.
  - Any other accepted byte is consumed and ignored; stay IDLE.
- REQ: self_check_out=1 for exactly this cycle; timer cleared; -> WAIT.
  - Net effect: self_check_out is high in the cycle after the accepting handshake.
- WAIT: timer increments each cycle, starting at 0 on the first WAIT cycle.
  - dsp_ready_in=1 -> RESP with tdata=8'h25.
  - Else if timer==TIMEOUT_CYCLES-1:
    - retry<MAX_RETRY -> retry+1, -> REQ.
    - Otherwise -> RESP with tdata=8'h2a.
  - dsp_ready_in and timeout in the same cycle: ready wins (8'h25).
- dsp_ready_in is ignored in IDLE, REQ and RESP. A ready arriving during REQ is not remembered.
- RESP: cmd2cpu_tvalid_out=1 and tlast=1 from the cycle after the decision.
  - tdata is held stable until cmd2cpu_tready_in=1.
  - On handshake: next cycle tvalid=0, tdata=0, retry=0, -> IDLE.
- Latency: dsp_ready_in sampled in WAIT at cycle k -> tvalid=1 at k+1.
  - With tready_in=1 at k+1, IDLE is reached and cmd_axis_tready_out=1 at k+2.
- Back-to-back: a new command presented while busy is stalled (tready=0), not dropped. It is accepted in the first IDLE cycle.
- Timer width: clog2(TIMEOUT_CYCLES). The timer never wraps because it is cleared on every REQ.
- Retry saturates at MAX_RETRY; retry_cnt_out is visible during WAIT and RESP.

Test Plan:
- TIMEOUT_CYCLES=16, MAX_RETRY=2 for all cases.
- Send 8'h21 at cycle 0; dsp_ready_in at the 5th WAIT cycle.
  - self_check_out=1 at cycle 1 only.
  - tvalid/tlast=1 with tdata=8'h25 the next cycle; retry_cnt_out=0.
- Send 8'h21 and never assert dsp_ready.
  - Exactly 3 self_check_out pulses, 17 cycles apart.
  - Then tdata=8'h2a, with retry_cnt_out=2 during RESP.
- First attempt times out; dsp_ready arrives on the last WAIT cycle of the 2nd attempt, coincident with its timeout.
  - Response is 8'h25 and retry_cnt_out=1 (ready wins over timeout).
- Hold cmd2cpu_tready_in=0 for 10 cycles in RESP.
  - tvalid and tdata=8'h25 stay stable throughout.
  - A second 8'h21 presented meanwhile sees tready=0.
  - It is accepted the cycle IDLE is re-entered and produces a new pulse.
- Send 8'h33 in IDLE.
  - Byte consumed; no self_check_out, no status byte, busy_out stays 0.
- Assert reset during WAIT of the 2nd attempt.
  - All outputs return to their reset values asynchronously.
  - No status byte is emitted.
  - A subsequent 8'h21 starts with retry_cnt_out=0.
